// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/execute sequencer for a Hack-style CPU
// Drives ROM fetches, latches the instruction, decides pc load vs increment, counts retires.
module pc_sequencer #(
  parameter int HALT_DETECT = 1,
  parameter int ROM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rom_ack,
  input  logic [15:0] rom_data,
  input  logic [15:0] pc_cur,
  input  logic [15:0] a_reg,
  input  logic        zr,
  input  logic        ng,
  input  logic        stall,
  output logic        rom_req,
  output logic [15:0] ir,
  output logic        exec_en,
  output logic        pc_load,
  output logic        pc_inc,
  output logic [15:0] pc_in,
  output logic        halted,
  output logic        fetch_err,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [7:0] TMO_INIT = 8'(ROM_TIMEOUT);

  state_t     state;
  state_t     state_next;
  logic [7:0] tmo_cnt;
  logic       jump;
  logic       self_jump;
  logic       retire;
  logic       tmo_expire;

  always_comb begin
    jump = 1'b0;
    if (ir[15]) begin
      case (ir[2:0])
        3'b000:  jump = 1'b0;
        3'b001:  jump = !zr && !ng;
        3'b010:  jump = zr;
        3'b011:  jump = !ng;
        3'b100:  jump = ng;
        3'b101:  jump = !zr;
        3'b110:  jump = zr || ng;
        default: jump = 1'b1;
      endcase
    end
  end

  // An unconditional jump onto itself can never make progress, so it parks the sequencer.
  assign self_jump  = (HALT_DETECT != 0) && ir[15] && (ir[2:0] == 3'b111) && (a_reg == pc_cur);
  assign retire     = (state == S_EXEC) && !stall;
  assign tmo_expire = (tmo_cnt <= 8'd1);
  assign pc_in      = a_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: state_next = S_WAIT;
      S_WAIT: begin
        if (rom_ack) begin
          state_next = S_EXEC;
        end else if (tmo_expire) begin
          state_next = S_HALT;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          state_next = self_jump ? S_HALT : S_FETCH;
        end
      end
      default: state_next = S_HALT;
    endcase
  end

  always_comb begin
    rom_req = 1'b0;
    exec_en = 1'b0;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    halted  = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH, S_WAIT: rom_req = 1'b1;
        S_EXEC: begin
          exec_en = 1'b1;
          if (!stall) begin
            pc_load = jump;
            pc_inc  = !jump;
          end
        end
        default: halted = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir        <= 16'h0000;
      retired   <= 16'h0000;
      fetch_err <= 1'b0;
      tmo_cnt   <= 8'd0;
    end else begin
      case (state)
        S_FETCH: tmo_cnt <= TMO_INIT;
        S_WAIT: begin
          if (rom_ack) begin
            ir <= rom_data;
          end else begin
            tmo_cnt <= tmo_cnt - 8'd1;
            if (tmo_expire) begin
              fetch_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
      if (retire) begin
        retired <= retired + 16'd1;
      end
    end
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter HALT_DETECT, default 1, meaning: 1 enables entry to HALT on an unconditional jump-to-self; 0 disables it.
REQ-002 SHALL have parameter ROM_TIMEOUT, default 15, meaning: maximum WAIT cycles before fetch_err; range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port rom_ack, input, 1 bit: ROM read data valid on rom_data this cycle.
REQ-006 SHALL have port rom_data, input, 16 bits: fetched instruction word.
REQ-007 SHALL have port pc_cur, input, 16 bits: current program counter value.
REQ-008 SHALL have port a_reg, input, 16 bits: jump target from the A register.
REQ-009 SHALL have port zr, input, 1 bit: ALU output equals zero; valid during EXEC.
REQ-010 SHALL have port ng, input, 1 bit: ALU output is negative; valid during EXEC.
REQ-011 SHALL have port stall, input, 1 bit: holds the sequencer in EXEC; no retire while high.
REQ-012 SHALL have port rom_req, output, 1 bit: fetch request to ROM.
REQ-013 SHALL have port ir, output, 16 bits: latched instruction register.
REQ-014 SHALL have port exec_en, output, 1 bit: datapath execute strobe.
REQ-015 SHALL have port pc_load, output, 1 bit: drives the program counter load input.
REQ-016 SHALL have port pc_inc, output, 1 bit: drives the program counter inc input.
REQ-017 SHALL have port pc_in, output, 16 bits: program counter load value; equals a_reg.
REQ-018 SHALL have port halted, output, 1 bit: sequencer is in HALT.
REQ-019 SHALL have port fetch_err, output, 1 bit: sticky flag, set on ROM timeout.
REQ-020 SHALL have port retired, output, 16 bits: count of retired instructions.

Function
REQ-021 SHALL implement states FETCH, WAIT, EXEC and HALT, encoded in a 2-bit state register.
REQ-022 FETCH: SHALL assert rom_req, load the timeout counter with ROM_TIMEOUT and go to WAIT the next cycle.
REQ-023 WAIT: SHALL keep rom_req high; on rom_ack, SHALL latch ir <= rom_data and go to EXEC.
REQ-024 WAIT: without rom_ack, SHALL decrement the timeout counter; on expiry, SHALL set fetch_err and go to HALT.
REQ-025 rom_ack outside WAIT SHALL be ignored.
REQ-026 EXEC: exec_en SHALL be high for every cycle spent in EXEC.
REQ-027 EXEC with stall=1: pc_load and pc_inc SHALL be 0, and the state and retired SHALL hold.
REQ-028 EXEC with stall=0: exactly one of pc_load or pc_inc SHALL be high (combinational), retired SHALL increment, and the next state SHALL be FETCH.
REQ-029 Jump condition SHALL be false when ir[15]=0 (A-instruction).
REQ-030 Jump condition when ir[15]=1 SHALL be selected by ir[2:0]: 000 none, 001 !zr&!ng, 010 zr, 011 !ng, 100 ng, 101 !zr, 110 zr|ng, 111 always.
REQ-031 When the jump condition is true, SHALL assert pc_load=1; otherwise SHALL assert pc_inc=1.
REQ-032 When HALT_DETECT=1, ir[15]=1, ir[2:0]=111 and a_reg==pc_cur, SHALL retire the instruction with pc_load=1 and go to HALT.
REQ-033 HALT: rom_req, exec_en, pc_load and pc_inc SHALL be 0 and halted SHALL be 1; only reset exits HALT.
REQ-034 retired SHALL wrap from 16'hFFFF to 0.
REQ-035 pc_load and pc_inc SHALL never be high together.

Reset
REQ-036 With reset high, the next state SHALL be FETCH, with ir=0, retired=0, fetch_err=0 and the timeout counter=0.
REQ-037 While reset is high, rom_req, exec_en, pc_load, pc_inc and halted SHALL be forced to 0.
REQ-038 Reset SHALL take priority over stall, rom_ack and HALT, including reset asserted mid-WAIT or mid-EXEC.

Verification
REQ-039 SHALL cover an A-instruction: release reset, rom_ack with 16'h0005 on the 2nd WAIT cycle -> one EXEC cycle with pc_inc=1, pc_load=0, retired=1, then rom_req high again.
REQ-040 SHALL cover a conditional jump: ir=16'hE302 (JEQ), zr=1, a_reg=16'h0040 -> pc_load=1, pc_in=16'h0040; same instruction with zr=0 -> pc_inc=1.
REQ-041 SHALL cover stall: stall high for 3 EXEC cycles -> exec_en high for 4 cycles, a single pc_inc pulse on the 4th cycle, retired +1.
REQ-042 SHALL cover halt detection: ir=16'hEA87 (0;JMP), a_reg=pc_cur=16'h0010 -> pc_load pulse, then halted=1 indefinitely, rom_req=0; with HALT_DETECT=0 -> fetches continue.
REQ-043 SHALL cover timeout: no rom_ack for 15 WAIT cycles -> fetch_err=1, halted=1; then reset -> fetch_err=0, state FETCH.
REQ-044 SHALL cover counter wrap: preload retired to 16'hFFFF via 65535 retires or force, then retire one -> retired=0.
